// File: rtl/key_encoder_8to3.sv
// key_encoder_8to3: debounced active-low 8-to-3 priority encoder with valid/ack handshake; define KEY_ENC_MULTI_EN to build the multi-press flag
module key_encoder_8to3 #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req_n,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic       multi
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
  state_t     state, state_nxt;
  logic [7:0] sync1, s_req_n, cnt, cnt_nxt;
  logic [2:0] cand, cand_nxt, pri, code_nxt;
  logic       valid_nxt, multi_nxt, multi_hit, active;
  assign active = s_req_n != 8'hFF;
`ifdef KEY_ENC_MULTI_EN
  assign multi_hit = $countones(~s_req_n) > 1;
`else
  assign multi_hit = 1'b0;
`endif
  // two-flop synchroniser for the asynchronous request lines
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1   <= 8'hFF;
      s_req_n <= 8'hFF;
    end else begin
      sync1   <= req_n;
      s_req_n <= sync1;
    end
  // index of the highest active-low line; later iterations win
  always_comb begin
    pri = 3'd0;
    for (int i = 0; i < 8; i++) if (!s_req_n[i]) pri = 3'(i);
  end
  // next-state and output-load logic
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    code_nxt  = code;
    valid_nxt = valid;
    multi_nxt = multi;
    case (state)
      IDLE:
        if (en && active) begin
          state_nxt = DEBOUNCE;
          cand_nxt  = pri;
          cnt_nxt   = 8'd0;
        end
      DEBOUNCE:
        if (!en || !active || pri != cand) state_nxt = IDLE;
        else if (cnt == LAST) begin
          state_nxt = HOLD;
          code_nxt  = cand;
          valid_nxt = 1'b1;
          multi_nxt = multi_hit;
        end else cnt_nxt = cnt + 8'd1;
      HOLD:
        if (ack) begin
          state_nxt = RELEASE;
          valid_nxt = 1'b0;
        end
      RELEASE:
        if (!active) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state, candidate, counter and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cand  <= 3'd0;
      cnt   <= 8'd0;
      code  <= 3'd0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
      code  <= code_nxt;
      valid <= valid_nxt;
      multi <= multi_nxt;
    end
endmodule

// File: tb/tb_key_encoder_8to3.sv
// tb_key_encoder_8to3: directed self-checking bench for key_encoder_8to3
module tb_key_encoder_8to3;
  logic       clk = 1'b0;
  logic       rst_n, en, ack;
  logic [7:0] req_n;
  logic [2:0] code;
  logic       valid, multi;
  int         n_cmp = 0;
  int         n_bad = 0;
`ifdef KEY_ENC_MULTI_EN
  localparam logic MULTI_EXP = 1'b1;
`else
  localparam logic MULTI_EXP = 1'b0;
`endif
  key_encoder_8to3 #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n), .ack(ack),
    .code(code), .valid(valid), .multi(multi)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    en    = 1'($urandom);
    ack   = 1'($urandom);
    req_n = 8'($urandom);
    #3;
    chk("rst_code", 8'(code), 8'd0);
    chk("rst_valid", 8'(valid), 8'd0);
    chk("rst_multi", 8'(multi), 8'd0);
    tick();
    rst_n = 1'b1;
    req_n = 8'hFF;
    en    = 1'b1;
    ack   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", 8'(valid), 8'd0);
    end
    req_n = 8'b11111011;
    tick(6);
    chk("press_pre", 8'(valid), 8'd0);
    tick();
    chk("press_valid", 8'(valid), 8'd1);
    chk("press_code", 8'(code), 8'd2);
    chk("press_multi", 8'(multi), 8'd0);
    ack_pulse();
    chk("ack_valid", 8'(valid), 8'd0);
    chk("ack_code_kept", 8'(code), 8'd2);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held_once", 8'(valid), 8'd0);
    end
    req_n = 8'hFF;
    tick(4);
    req_n = 8'b11111011;
    tick(6);
    chk("repress_pre", 8'(valid), 8'd0);
    tick();
    chk("repress_valid", 8'(valid), 8'd1);
    ack_pulse();
    req_n = 8'hFF;
    tick(4);
    req_n = 8'b01101110;
    tick(6);
    chk("pri_pre", 8'(valid), 8'd0);
    tick();
    chk("pri_valid", 8'(valid), 8'd1);
    chk("pri_code", 8'(code), 8'd7);
    chk("pri_multi", 8'(multi), 8'(MULTI_EXP));
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("long_ack", 8'(valid), 8'd0);
    end
    ack = 1'b0;
    req_n = 8'hFF;
    tick(4);
    for (int i = 0; i < 10; i++) begin
      req_n = (i % 2 == 0) ? 8'hF7 : 8'hFF;
      tick(2);
      chk("bounce", 8'(valid), 8'd0);
    end
    req_n = 8'hF7;
    tick(6);
    chk("bounce_pre", 8'(valid), 8'd0);
    tick();
    chk("bounce_valid", 8'(valid), 8'd1);
    chk("bounce_code", 8'(code), 8'd3);
    ack_pulse();
    req_n = 8'hFF;
    tick(4);
    en    = 1'b0;
    req_n = 8'hDF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en_low", 8'(valid), 8'd0);
    end
    en = 1'b1;
    tick(2);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick(3);
    chk("en_abort", 8'(valid), 8'd0);
    en = 1'b0;
    tick(6);
    en = 1'b1;
    tick(4);
    chk("en_pre", 8'(valid), 8'd0);
    tick();
    chk("en_valid", 8'(valid), 8'd1);
    chk("en_code", 8'(code), 8'd5);
    en    = 1'b0;
    req_n = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_en_low", 8'(valid), 8'd1);
      chk("hold_code", 8'(code), 8'd5);
    end
    ack_pulse();
    chk("hold_ack", 8'(valid), 8'd0);
    en    = 1'b1;
    req_n = 8'hFF;
    tick(4);
    req_n = 8'b11111011;
    tick(7);
    chk("pre_rst_valid", 8'(valid), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 8'(valid), 8'd0);
    chk("async_code", 8'(code), 8'd0);
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_pre", 8'(valid), 8'd0);
    tick();
    chk("post_rst_valid", 8'(valid), 8'd1);
    chk("post_rst_code", 8'(code), 8'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/key_encoder_8to3.md
# key_encoder_8to3

Debounced 8-to-3 priority encoder for eight active-low request lines, such as push-buttons or decoder-style select lines. It synchronises and debounces the inputs, then encodes the highest-index active line into a 3-bit code. The code is delivered once per press through a valid/ack handshake. It is the return path for the 3-to-8 active-low select decoder: it turns a one-of-eight active-low pattern back into a binary index for the control logic.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive cycles the same winning input must stay stable before it is accepted; legal range 1..255.

Ports:
- clk  input  1  single system clock; all flops use the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  encoder enable, active high; when low, no new press is accepted.
- req_n  input  8  asynchronous request lines, active low; bit 7 has highest priority.
- ack  input  1  consumer acknowledge; sampled only while valid=1.
- code  output  3  registered index of the accepted request line.
- valid  output  1  high while code holds an accepted, unacknowledged press.
- multi  output  1  registered flag: more than one line was active at acceptance.

## Operation
- Synchroniser: req_n passes through a 2-flop synchroniser; reset value 8'hFF. The FSM sees only the synchronised value, called s_req_n below.
- Priority function: pri(x) is the index of the highest bit i with x[i]=0. It is undefined when x=8'hFF (no line active).
- Reset values: state=IDLE, code=3'b000, valid=0, multi=0, debounce counter=0.
- FSM states and transitions:
  - IDLE: if en=1 and s_req_n≠8'hFF, capture cand=pri(s_req_n), clear the counter, and go to DEBOUNCE.
  - DEBOUNCE, abort case: if en=0, or s_req_n=8'hFF, or pri(s_req_n)≠cand, return to IDLE. No output changes.
  - DEBOUNCE, accept case: if the counter equals DEBOUNCE_CYCLES-1, go to HOLD. On the same edge load code=cand, set valid=1, and load multi.
  - DEBOUNCE, otherwise: increment the counter.
  - HOLD: valid stays 1 and code stays stable. When ack=1 at a clock edge, clear valid and go to RELEASE. Changes on en or req_n have no effect in this state.
  - RELEASE: when s_req_n=8'hFF at a clock edge, go to IDLE. A held press is therefore reported exactly once.
- ack outside HOLD is ignored.
- The counter width is 8 bits. It never wraps, because it stops at DEBOUNCE_CYCLES-1.
- If a higher-priority line becomes active during DEBOUNCE, that is an abort; the new winner restarts from IDLE on the next cycle.
- code keeps its last value after ack; only valid indicates whether it is meaningful.

## Timing
- Acceptance latency: assume a stable pattern is present before edge 0. s_req_n is valid after edge 1. DEBOUNCE is entered at edge 2. HOLD is entered and valid rises at edge 2+DEBOUNCE_CYCLES.
- Handshake:
  - valid falls at the first edge where ack=1 is sampled.
  - An ack held high for many cycles is harmless.
  - The earliest next acceptance requires one RELEASE cycle with s_req_n=8'hFF, then the full latency again.
- Reset asserted mid-operation forces all state and outputs to their reset values immediately (asynchronously). Release of reset takes effect at the next clock edge.

## Configuration
- KEY_ENC_MULTI_EN defined: multi is loaded at acceptance with 1 if two or more bits of s_req_n are 0, otherwise 0.
- KEY_ENC_MULTI_EN undefined: multi is constant 0 and no population-count logic is built.
- The port list is identical in both builds.

## Test plan
- Reset: assert rst_n=0 with random inputs -> code=0, valid=0, multi=0. After release with req_n=8'hFF, valid stays 0 for 20 cycles.
- Single press with DEBOUNCE_CYCLES=4: drive req_n=8'b11111011, en=1 -> valid rises at edge 6 with code=3'd2. Pulse ack for one cycle -> valid=0. Keep the line held for 20 cycles -> no second valid. Release, then press again -> valid again.
- Priority and multi: drive req_n=8'b01101110 -> code=3'd7. multi=1 when built with KEY_ENC_MULTI_EN, multi=0 without it.
- Bounce: toggle bit 3 every 2 cycles for 20 cycles, then hold it low -> valid rises exactly 2+4 cycles after the last stable edge, with code=3'd3.
- Enable: en=0 with bit 5 low -> no valid. Deassert en during DEBOUNCE -> abort, no valid. Deassert en during HOLD -> valid stays high until ack.
- Mid-operation reset: assert rst_n during HOLD -> valid drops asynchronously. After release, the held key is accepted again after the full latency.
